dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data-memory port. Replaces the single-cycle data memory with a handshaked, fixed-latency SRAM model.
- Accepts one load or store request at a time and performs byte/half/word lane selection and merging.
- Holds the pipeline with `Stall` until the response cycle.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/lane_merge.sv | 61 ++++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Contents: access-size codes, FSM state encoding, request payload
// struct, byte-lane width and a byte-enable helper.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Request as captured at the accept edge
    typedef struct packed {
        logic              write;
        mem_size_e         size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Little-endian byte enables for a given size and byte offset
    function automatic logic [BE_W-1:0] byte_en(input mem_size_e size, input logic [1:0] off);
        case (size)
            SIZE_WORD: byte_en = {BE_W{1'b1}};
            SIZE_HALF: byte_en = off[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
            SIZE_BYTE: byte_en = BE_W'(4'b0001 << off);
            SIZE_ILL:  byte_en = '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory port between the pipeline and the responder.
// master: pipeline side (drives request, sees response/stall).
// slave:  responder side.
interface dmem_responder_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        AddrErr;
    logic        Stall;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqAddr, ReqWData,
        input  ReqReady, RespValid, RespData, AddrErr, Stall
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqAddr, ReqWData,
        output ReqReady, RespValid, RespData, AddrErr, Stall
    );

endinterface

// File: rtl/lane_merge.sv
// Combinational byte/half/word lane logic for one memory word.
// Ports: size_i, off_i (addr[1:0]), old_i (current word), wdata_i (store data)
//        merged_c_o (word after store merge), load_c_o (right-justified,
//        zero-extended load data), misaligned_c_o (alignment violation).
module lane_merge
    import mem_pkg::*;
(
    input  mem_size_e         size_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] merged_c_o,
    output logic [DATA_W-1:0] load_c_o,
    output logic              misaligned_c_o
);

    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] lanes_c;
    logic [DATA_W-1:0] shifted_c;

    assign be_c      = byte_en(size_i, off_i);
    assign shifted_c = old_i >> {off_i, 3'b000};

    // Replicate the low store lane across the word so any enabled lane picks it up
    always_comb begin
        lanes_c = wdata_i;
        case (size_i)
            SIZE_HALF: lanes_c = {2{wdata_i[15:0]}};
            SIZE_BYTE: lanes_c = {4{wdata_i[7:0]}};
            default:   lanes_c = wdata_i;
        endcase
    end

    // Read-modify-write: unselected bytes keep the old value
    always_comb begin
        merged_c_o = old_i;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be_c[i]) merged_c_o[8*i +: 8] = lanes_c[8*i +: 8];
        end
    end

    always_comb begin
        load_c_o = '0;
        case (size_i)
            SIZE_WORD: load_c_o = old_i;
            SIZE_HALF: load_c_o = {16'h0000, shifted_c[15:0]};
            SIZE_BYTE: load_c_o = {24'h000000, shifted_c[7:0]};
            default:   load_c_o = '0;
        endcase
    end

    always_comb begin
        misaligned_c_o = 1'b0;
        case (size_i)
            SIZE_WORD: misaligned_c_o = (off_i != 2'b00);
            SIZE_HALF: misaligned_c_o = off_i[0];
            default:   misaligned_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data-memory responder for the MEM stage.
// Ports: Clk, Reset (async, active-low), bus (slave modport of
//        dmem_responder_if: request in, registered response out, Stall).
// One access in flight; the array is touched on the edge entering RESP.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q;
    mem_req_t          live_c;
    mem_req_t          acc_c;
    logic              cap_en_c;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] old_c;
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] load_c;
    logic              mis_c;
    logic              oor_c;
    logic              err_c;
    logic              enter_resp_c;
    logic              we_c;

    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              addr_err_q, addr_err_d;

    always_comb begin
        live_c.write = bus.ReqWrite;
        live_c.size  = mem_size_e'(bus.ReqSize);
        live_c.addr  = bus.ReqAddr;
        live_c.wdata = bus.ReqWData;
    end

    // With LATENCY=1 the access edge is also the accept edge, so use the live request
    assign acc_c = (state_q == IDLE) ? live_c : req_q;

    assign idx_c = acc_c.addr[IDX_W+1:2];
    assign old_c = mem_q[idx_c];
    assign oor_c = |acc_c.addr[ADDR_W-1:IDX_W+2];
    assign err_c = oor_c | mis_c | (acc_c.size == SIZE_ILL);

    lane_merge u_lane_merge (
        .size_i         (acc_c.size),
        .off_i          (acc_c.addr[1:0]),
        .old_i          (old_c),
        .wdata_i        (acc_c.wdata),
        .merged_c_o     (merged_c),
        .load_c_o       (load_c),
        .misaligned_c_o (mis_c)
    );

    // Next-state and counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    cap_en_c = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp_c = (state_d == RESP) && (state_q != RESP);
    // Reset gate keeps an aborted access from writing while reset is held
    assign we_c         = enter_resp_c & acc_c.write & ~err_c & Reset;

    // Response payload is only nonzero in the RESP cycle
    always_comb begin
        resp_data_d = '0;
        addr_err_d  = 1'b0;
        if (enter_resp_c) begin
            addr_err_d = err_c;
            if (!err_c && !acc_c.write) resp_data_d = load_c;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            resp_data_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            addr_err_q  <= addr_err_d;
            if (cap_en_c) req_q <= live_c;
        end
    end

    // Array is not reset
    always_ff @(posedge Clk) begin
        if (we_c) mem_q[idx_c] <= merged_c;
    end

    assign bus.ReqReady  = (state_q == IDLE);
    assign bus.RespValid = (state_q == RESP);
    assign bus.RespData  = resp_data_q;
    assign bus.AddrErr   = addr_err_q;
    assign bus.Stall     = bus.ReqValid && (state_q != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model
// produces expected responses at accept time; a negedge monitor pops
// and compares whenever RespValid is seen.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 128;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned NBYTES  = DEPTH * 4;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  mdl [NBYTES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory as a flat little-endian byte array
    task automatic model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int n;
        n   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        err = (sz == 2'd3) || (a >= NBYTES) || ((a % 32'(n)) != 0);
        rd  = '0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (w) mdl[a + 32'(i)] = wd[8*i +: 8];
                else   rd[8*i +: 8]    = mdl[a + 32'(i)];
            end
        end
    endtask

    // Present a request, push expectation on accept, return at the RESP cycle
    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit drop, output int resp_cyc);
        bit   accepted = 0;
        bit   got      = 0;
        int   n_stall  = 0;
        exp_t e;
        resp_cyc     = -1;
        bus.ReqWrite = w;
        bus.ReqSize  = sz;
        bus.ReqAddr  = a;
        bus.ReqWData = wd;
        bus.ReqValid = 1'b1;
        #1;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.Stall === 1'b1) n_stall++;
            if (!accepted && bus.ReqValid && bus.ReqReady === 1'b1) begin
                accepted = 1;
                model(w, sz, a, wd, e.data, e.err);
                e.cyc = cyc + int'(LATENCY);
                sb.push_back(e);
            end else if (accepted && drop) begin
                bus.ReqValid = 1'b0;
            end
            if (accepted && bus.RespValid === 1'b1) begin
                got      = 1;
                resp_cyc = cyc;
            end else begin
                @(negedge Clk);
                #1;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL req_timeout addr=%h accepted=%0d (no RespValid)", a, accepted);
        end else if (!drop) begin
            chk("stall_cycles", 32'(n_stall), 32'(LATENCY));
        end
    endtask

    task automatic idle(input int n);
        bus.ReqValid = 1'b0;
        repeat (n) begin
            @(negedge Clk);
            #1;
            chk("idle_ready", 32'(bus.ReqReady), 32'd1);
            chk("idle_stall", 32'(bus.Stall), 32'd0);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (Reset === 1'b1 && bus.RespValid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual RespValid=1 expected no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_data", bus.RespData, mon_e.data);
                chk("resp_err", 32'(bus.AddrErr), 32'(mon_e.err));
                chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int          r1, r2;
    logic [31:0] ra;
    logic [1:0]  rsz;
    logic        rw;
    bit          rdrop;

    initial begin
        Reset        = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqSize  = 2'd0;
        bus.ReqAddr  = '0;
        bus.ReqWData = '0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_ready", 32'(bus.ReqReady), 32'd1);
        chk("rst_respvalid", 32'(bus.RespValid), 32'd0);
        chk("rst_respdata", bus.RespData, 32'd0);
        chk("rst_addrerr", 32'(bus.AddrErr), 32'd0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        idle(1);

        // Fill every word so model and array agree
        for (int i = 0; i < int'(DEPTH); i++) do_req(1'b1, 2'd0, 32'(i * 4), $urandom(), 1'b0, r1);
        idle(1);

        // Reset mid-WAIT aborts the store
        bus.ReqWrite = 1'b1;
        bus.ReqSize  = 2'd0;
        bus.ReqAddr  = 32'h10;
        bus.ReqWData = 32'hDEADBEEF;
        bus.ReqValid = 1'b1;
        #1;
        chk("t1_ready_accept", 32'(bus.ReqReady), 32'd1);
        @(negedge Clk);
        #1;
        chk("t1_ready_wait", 32'(bus.ReqReady), 32'd0);
        chk("t1_stall_wait", 32'(bus.Stall), 32'd1);
        Reset = 1'b0;
        #1;
        chk("t1_ready_rst", 32'(bus.ReqReady), 32'd1);
        chk("t1_respvalid_rst", 32'(bus.RespValid), 32'd0);
        chk("t1_respdata_rst", bus.RespData, 32'd0);
        chk("t1_addrerr_rst", 32'(bus.AddrErr), 32'd0);
        @(negedge Clk);
        bus.ReqValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("t1_ready_release", 32'(bus.ReqReady), 32'd1);
        do_req(1'b0, 2'd0, 32'h10, 32'h0, 1'b0, r1);
        idle(1);

        // Word store then load
        do_req(1'b1, 2'd0, 32'h20, 32'h12345678, 1'b0, r1);
        idle(1);
        do_req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, r1);
        idle(1);

        // Sub-word merge and extraction (junk above the store lane)
        do_req(1'b1, 2'd2, 32'h21, 32'hFFFFFFAB, 1'b0, r1);
        do_req(1'b1, 2'd1, 32'h22, 32'h5555CDEF, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd2, 32'h23, 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd1, 32'h20, 32'h0, 1'b0, r1);
        idle(1);

        // Misaligned and illegal-size requests
        do_req(1'b0, 2'd0, 32'h22, 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd1, 32'h21, 32'h0, 1'b0, r1);
        do_req(1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, 1'b0, r1);
        do_req(1'b1, 2'd0, 32'h26, 32'hFFFFFFFF, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'h24, 32'h0, 1'b0, r1);
        idle(1);

        // Out of range: no aliasing onto word 0; last word still legal
        do_req(1'b1, 2'd0, 32'h200, 32'hA5A5A5A5, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, r1);
        do_req(1'b1, 2'd0, 32'(NBYTES - 4), 32'hCAFEF00D, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'(NBYTES - 4), 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd2, 32'(NBYTES), 32'h0, 1'b0, r1);
        idle(1);

        // Back-to-back with ReqValid held, then a flush during WAIT
        do_req(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, r1);
        do_req(1'b0, 2'd0, 32'h24, 32'h0, 1'b0, r2);
        chk("b2b_gap", 32'(r2 - r1), 32'(LATENCY + 1));
        do_req(1'b0, 2'd0, 32'h20, 32'h0, 1'b1, r1);
        idle(2);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       ra = $urandom() | 32'h200;
                1:       ra = 32'(NBYTES - 4) + $urandom_range(0, 7);
                default: ra = $urandom_range(0, NBYTES - 1);
            endcase
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            rdrop = ($urandom_range(0, 9) == 0);
            do_req(rw, rsz, ra, $urandom(), rdrop, r1);
            if (rdrop || $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
